// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Optional WAIT-state timeout is enabled by defining SPI_TXN_TIMEOUT_EN.
package spi_txn_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_STRT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    localparam logic [2:0] SS_NONE   = 3'b111;
    localparam logic [2:0] SS_VALID0 = 3'b000;
    localparam logic [2:0] SS_VALID1 = 3'b001;
    localparam logic [2:0] SS_VALID2 = 3'b010;

    function automatic logic ss_is_valid(input logic [2:0] ss);
        return (ss == SS_VALID0) || (ss == SS_VALID1) || (ss == SS_VALID2);
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Client request/grant bus plus the SPI master control/status lines.
// slave = arbiter view, master = client/master-side view.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [3*NUM_REQ-1:0]      req_ss;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      ack;
    logic                      err;
    logic [DATA_W-1:0]         rx_data;
    logic                      busy;
    logic                      start;
    logic [2:0]                ss_out;
    logic [DATA_W-1:0]         data_out;
    logic                      master_done;
    logic [DATA_W-1:0]         master_rx;

    modport slave (
        input  req, req_ss, req_data, master_done, master_rx,
        output gnt, ack, err, rx_data, busy, start, ss_out, data_out
    );

    modport master (
        output req, req_ss, req_data, master_done, master_rx,
        input  gnt, ack, err, rx_data, busy, start, ss_out, data_out
    );
endinterface

// File: rtl/spi_txn_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module spi_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    int idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                win_idx   = IDX_W'(idx);
                win_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oh
        assign win_oh[gi] = win_valid && (win_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// Define SPI_TXN_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles with ERR.
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    spi_txn_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("spi_txn_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    logic [2:0]        ss_arr   [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign ss_arr[gi]   = bus.req_ss[3*gi +: 3];
        assign data_arr[gi] = bus.req_data[DATA_W*gi +: DATA_W];
    end

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   win_idx_reg;
    logic [2:0]         ss_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               ack_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  rx_data_reg;
    logic               busy_reg;
    logic               start_reg;
    logic [2:0]         ss_out_reg;
    logic [DATA_W-1:0]  data_out_reg;

`ifdef SPI_TXN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_reg;
`endif

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (bus.req),
        .ptr       (rr_ptr_reg),
        .win_oh    (pick_oh),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            win_idx_reg  <= '0;
            ss_reg       <= SS_NONE;
            data_reg     <= '0;
            gnt_reg      <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rx_data_reg  <= '0;
            busy_reg     <= 1'b0;
            start_reg    <= 1'b0;
            ss_out_reg   <= SS_NONE;
            data_out_reg <= '0;
`ifdef SPI_TXN_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
        end else begin
            ack_reg   <= 1'b0;
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_reg     <= pick_oh;
                        win_idx_reg <= pick_idx;
                        ss_reg      <= ss_arr[pick_idx];
                        data_reg    <= data_arr[pick_idx];
                        err_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (ss_is_valid(ss_reg)) begin
                        ss_out_reg   <= ss_reg;
                        data_out_reg <= data_reg;
                        start_reg    <= 1'b1;
                        state_reg    <= ST_STRT;
                    end else begin
                        // Rejected: the master never sees this request.
                        err_reg   <= 1'b1;
                        ack_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_STRT: begin
`ifdef SPI_TXN_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.master_done) begin
                        rx_data_reg <= bus.master_rx;
                        err_reg     <= 1'b0;
                        ack_reg     <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
`ifdef SPI_TXN_TIMEOUT_EN
                    else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_reg    <= 1'b1;
                        ack_reg    <= 1'b1;
                        ss_out_reg <= SS_NONE;
                        state_reg  <= ST_DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    gnt_reg    <= '0;
                    ss_out_reg <= SS_NONE;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= (win_idx_reg == IDX_W'(NUM_REQ - 1)) ?
                                  '0 : win_idx_reg + IDX_W'(1);
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_reg;
    assign bus.ack      = ack_reg;
    assign bus.err      = err_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.busy     = busy_reg;
    assign bus.start    = start_reg;
    assign bus.ss_out   = ss_out_reg;
    assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed self-checking bench for spi_txn_arbiter (3 requesters, 8-bit words).
module tb_spi_txn_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    spi_txn_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    spi_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full valid transfer starting in IDLE with the request already raised.
    task automatic xfer(input string tag, input logic [2:0] exp_gnt, input logic [2:0] exp_ss,
                        input logic [7:0] exp_data, input logic [7:0] rx_word);
        tick();
        check_eq({tag, "_gnt"}, bus.gnt, exp_gnt);
        check_eq({tag, "_busy"}, bus.busy, 1);
        check_eq({tag, "_nostart"}, bus.start, 0);
        tick();
        check_eq({tag, "_start"}, bus.start, 1);
        check_eq({tag, "_ss"}, bus.ss_out, exp_ss);
        check_eq({tag, "_data"}, bus.data_out, exp_data);
        tick();
        check_eq({tag, "_start_off"}, bus.start, 0);
        check_eq({tag, "_ack_early"}, bus.ack, 0);
        bus.master_done = 1'b1;
        bus.master_rx   = rx_word;
        tick();
        bus.master_done = 1'b0;
        check_eq({tag, "_ack"}, bus.ack, 1);
        check_eq({tag, "_err"}, bus.err, 0);
        check_eq({tag, "_rx"}, bus.rx_data, rx_word);
        check_eq({tag, "_gnt_ack"}, bus.gnt, exp_gnt);
        tick();
        check_eq({tag, "_ack_off"}, bus.ack, 0);
        check_eq({tag, "_gnt_off"}, bus.gnt, 0);
        check_eq({tag, "_ss_idle"}, bus.ss_out, 3'b111);
        check_eq({tag, "_idle"}, bus.busy, 0);
        $display("xfer %s: gnt=%b ss=%b data=%h rx=%h", tag, exp_gnt, exp_ss, exp_data, rx_word);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.req          = '0;
        bus.req_ss       = '0;
        bus.req_data     = '0;
        bus.master_done  = 1'b0;
        bus.master_rx    = '0;
        tick();
        tick();
        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_ack", bus.ack, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_rx", bus.rx_data, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_start", bus.start, 0);
        check_eq("rst_ss", bus.ss_out, 3'b111);
        check_eq("rst_data", bus.data_out, 0);
        $display("reset: outputs at idle values");
        rst = 1'b0;

        // Single transfer from requester 0.
        bus.req_ss   = 9'b111_111_000;
        bus.req_data = 24'h0000A5;
        bus.req      = 3'b001;
        xfer("single", 3'b001, 3'b000, 8'hA5, 8'h5A);
        bus.req = 3'b000;

        // Re-align rr_ptr to 0, then all three requesters held high.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_ss   = 9'b010_001_000;
        bus.req_data = 24'h332211;
        bus.req      = 3'b111;
        xfer("rr0", 3'b001, 3'b000, 8'h11, 8'h81);
        xfer("rr1", 3'b010, 3'b001, 8'h22, 8'h82);
        xfer("rr2", 3'b100, 3'b010, 8'h33, 8'h83);
        xfer("rr3", 3'b001, 3'b000, 8'h11, 8'h84);
        bus.req = 3'b000;

        // Invalid slave select on requester 1: rejected without touching the master.
        bus.req_ss = 9'b000_111_000;
        bus.req    = 3'b010;
        tick();
        check_eq("bad_gnt", bus.gnt, 3'b010);
        check_eq("bad_ack_early", bus.ack, 0);
        tick();
        check_eq("bad_ack", bus.ack, 1);
        check_eq("bad_err", bus.err, 1);
        check_eq("bad_nostart", bus.start, 0);
        check_eq("bad_ss", bus.ss_out, 3'b111);
        check_eq("bad_rx_kept", bus.rx_data, 8'h84);
        bus.req = 3'b000;
        tick();
        check_eq("bad_ack_off", bus.ack, 0);
        check_eq("bad_gnt_off", bus.gnt, 0);
        check_eq("bad_idle", bus.busy, 0);
        $display("xfer bad_ss: gnt=010 err=1");

        // MASTER_DONE during STRT must be ignored.
        bus.req_ss   = 9'b000_000_000;
        bus.req_data = 24'h00003C;
        bus.req      = 3'b001;
        tick();
        check_eq("strt_gnt", bus.gnt, 3'b001);
        tick();
        check_eq("strt_start", bus.start, 1);
        bus.master_done = 1'b1;
        bus.master_rx   = 8'hEE;
        tick();
        bus.master_done = 1'b0;
        check_eq("strt_ignored", bus.ack, 0);
        tick();
        check_eq("strt_wait", bus.ack, 0);
        check_eq("strt_rx_kept", bus.rx_data, 8'h84);
        bus.master_done = 1'b1;
        bus.master_rx   = 8'hC3;
        tick();
        bus.master_done = 1'b0;
        check_eq("strt_ack", bus.ack, 1);
        check_eq("strt_rx", bus.rx_data, 8'hC3);
        bus.req = 3'b000;
        tick();
        check_eq("strt_gnt_off", bus.gnt, 0);
        $display("xfer strt_done: early MASTER_DONE ignored rx=c3");

        // Asynchronous reset while waiting on the master.
        bus.req_ss   = 9'b010_000_000;
        bus.req_data = 24'h550000;
        bus.req      = 3'b100;
        tick();
        check_eq("rw_gnt", bus.gnt, 3'b100);
        tick();
        check_eq("rw_ss", bus.ss_out, 3'b010);
        check_eq("rw_data", bus.data_out, 8'h55);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rw_start", bus.start, 0);
        check_eq("rw_ss_idle", bus.ss_out, 3'b111);
        check_eq("rw_gnt_off", bus.gnt, 0);
        check_eq("rw_busy", bus.busy, 0);
        check_eq("rw_rx", bus.rx_data, 0);
        $display("reset mid-WAIT: outputs cleared");
        bus.req_ss   = 9'b000_000_000;
        bus.req_data = 24'h000077;
        bus.req      = 3'b001;
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer("recover", 3'b001, 3'b000, 8'h77, 8'h99);
        bus.req = 3'b000;

`ifdef SPI_TXN_TIMEOUT_EN
        // Master never completes: WAIT gives up after TIMEOUT_CYC cycles.
        bus.req = 3'b001;
        tick();
        check_eq("tmo_gnt", bus.gnt, 3'b001);
        tick();
        check_eq("tmo_start", bus.start, 1);
        tick();
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            tick();
        end
        check_eq("tmo_ack_early", bus.ack, 0);
        tick();
        check_eq("tmo_ack", bus.ack, 1);
        check_eq("tmo_err", bus.err, 1);
        check_eq("tmo_ss", bus.ss_out, 3'b111);
        check_eq("tmo_rx_kept", bus.rx_data, 8'h99);
        bus.req = 3'b000;
        tick();
        check_eq("tmo_gnt_off", bus.gnt, 0);
        $display("xfer timeout: err=1 after %0d cycles", TIMEOUT_CYC);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
